// File: rtl/logit_frame_collector.sv
// Collects NUM_CLASSES signed scores from a valid/ready stream into one flat vector and holds
// it for the downstream argmax stage; flags framing errors and counts delivered frames.
module logit_frame_collector #(
    parameter int unsigned BIT_WIDTH       = 8,
    parameter int unsigned NUM_CLASSES     = 10,
    parameter int unsigned CNT_WIDTH       = 4,
    parameter int unsigned FRAME_CNT_WIDTH = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [BIT_WIDTH-1:0]             in_data_i,
    input  logic                             in_last_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [BIT_WIDTH*NUM_CLASSES-1:0] out_vec_o,
    output logic                             frame_err_o,
    output logic [FRAME_CNT_WIDTH-1:0]       frame_count_o
);

    localparam int unsigned VecW = BIT_WIDTH * NUM_CLASSES;
    localparam logic [CNT_WIDTH-1:0] LastSlot = CNT_WIDTH'(NUM_CLASSES - 1);
    localparam logic [BIT_WIDTH-1:0] MinVal = {1'b1, {(BIT_WIDTH - 1){1'b0}}};

    typedef enum logic {StFill, StFull} state_e;

    state_e                       state_q, state_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic [VecW-1:0]              buf_q, buf_d;
    logic [VecW-1:0]              out_vec_q, out_vec_d;
    logic                         frame_err_q, frame_err_d;
    logic [FRAME_CNT_WIDTH-1:0]   frame_count_q, frame_count_d;

    logic                 accept, deliver, complete, last_slot, early_last;
    logic [CNT_WIDTH-1:0] slot;
    logic [VecW-1:0]      frame_d;

    assign accept  = in_valid_i && in_ready_o;
    assign deliver = out_valid_o && out_ready_i;

    // An accept while FULL is always the first beat of the next frame.
    assign slot       = (state_q == StFull) ? '0 : cnt_q;
    assign last_slot  = (slot == LastSlot);
    assign early_last = in_last_i && !last_slot;
    assign complete   = accept && (last_slot || in_last_i);

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill: if (complete) state_d = StFull;
            StFull: if (deliver) state_d = complete ? StFull : StFill;
            default: state_d = StFill;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid_o = (state_q == StFull);
        in_ready_o  = !reset_i && ((state_q == StFill) || out_ready_i);
    end

    // Datapath: buffer gets the beat, padded slots are only filled on an early last
    always_comb begin
        frame_d = buf_q;
        for (int i = 0; i < int'(NUM_CLASSES); i++) begin
            if (i == int'(slot)) begin
                frame_d[BIT_WIDTH*i +: BIT_WIDTH] = in_data_i;
            end else if (complete && (i > int'(slot))) begin
                frame_d[BIT_WIDTH*i +: BIT_WIDTH] = MinVal;
            end
        end
        buf_d         = accept ? frame_d : buf_q;
        out_vec_d     = complete ? frame_d : out_vec_q;
        cnt_d         = accept ? (complete ? '0 : slot + CNT_WIDTH'(1)) : cnt_q;
        frame_err_d   = frame_err_q || (accept && (early_last || (last_slot && !in_last_i)));
        frame_count_d = frame_count_q + FRAME_CNT_WIDTH'(deliver);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q         <= '0;
            buf_q         <= '0;
            out_vec_q     <= '0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            buf_q         <= buf_d;
            out_vec_q     <= out_vec_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign out_vec_o     = out_vec_q;
    assign frame_err_o   = frame_err_q;
    assign frame_count_o = frame_count_q;

endmodule
